// File: rtl/cpu_axi_rd_rr_arb_pkg.sv
// Shared definitions for the CPU AXI read round-robin arbiter: FSM encoding,
// master IDs and the AXI burst/size codes the CPU masters drive.
package cpu_axi_rd_rr_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic INST_MASTER = 1'b0;
    localparam logic DATA_MASTER = 1'b1;

    // IDs at the default 4-bit ID width; the arbiter replicates the grant bit
    // so any ID width gives all-zeros for fetch and all-ones for data.
    localparam logic [3:0] INST_ID = 4'h0;
    localparam logic [3:0] DATA_ID = 4'hF;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_1B = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    // Two-way round robin: on contention the master that did not win last time.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        return (req == 2'b11) ? ~last_grant : req[1];
    endfunction

endpackage

// File: rtl/cpu_axi_rd_rr_arb_if.sv
// Read-address / read-data bundle between one CPU master and the arbiter.
interface cpu_axi_rd_rr_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rlast;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/cpu_axi_rr_grant.sv
// Two-input round-robin grant; last_grant only moves when a burst completes.
module cpu_axi_rr_grant
    import cpu_axi_rd_rr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_id,
    output logic       grant_valid,
    output logic       grant_id
);
    logic last_grant;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b0;
        end else if (update) begin
            last_grant <= update_id;
        end
    end

    assign grant_valid = |req;
    assign grant_id    = rr_pick(req, last_grant);

endmodule

// File: rtl/cpu_axi_rd_rr_arb.sv
// Round-robin AR/R arbiter sharing one AXI read port between CPU fetch (m0) and
// data (m1). Define CPU_AXI_RD_ARB_PERF_EN to add grant/wait performance counters.
module cpu_axi_rd_rr_arb
    import cpu_axi_rd_rr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    cpu_axi_rd_rr_arb_if.slave    m0,
    cpu_axi_rd_rr_arb_if.slave    m1,
    output logic [ID_WIDTH-1:0]   s_axi_arid,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [7:0]            s_axi_arlen,
    output logic [2:0]            s_axi_arsize,
    output logic [1:0]            s_axi_arburst,
    output logic                  s_axi_arlock,
    output logic [3:0]            s_axi_arcache,
    output logic [2:0]            s_axi_arprot,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [ID_WIDTH-1:0]   s_axi_rid,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rlast,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    output logic                  arb_err
`ifdef CPU_AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]           perf_m0_grants,
    output logic [31:0]           perf_m1_grants,
    output logic [31:0]           perf_m0_wait
`endif
);
    logic [1:0]            state_r;
    logic                  grant_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [7:0]            len_r;
    logic [2:0]            size_r;
    logic [1:0]            burst_r;
    logic                  arvalid_r;
    logic [7:0]            beat_cnt;
    logic                  arb_err_r;

    logic        gnt_valid;
    logic        gnt_id;
    logic        idle_grant;
    logic        last_beat;
    logic        beat_hs;
    logic        burst_done;
    logic [31:0] sel_addr;

    cpu_axi_rr_grant u_grant (
        .clk         (clk),
        .resetn      (resetn),
        .req         ({m1.arvalid, m0.arvalid}),
        .update      (burst_done),
        .update_id   (grant_r),
        .grant_valid (gnt_valid),
        .grant_id    (gnt_id)
    );

    // Gated by resetn so arready cannot pulse while reset holds the FSM in IDLE.
    assign idle_grant = resetn && (state_r == ST_IDLE) && gnt_valid;
    assign last_beat  = (beat_cnt == len_r);
    assign beat_hs    = (state_r == ST_DATA) && s_axi_rvalid && s_axi_rready;
    assign burst_done = beat_hs && last_beat;
    assign sel_addr   = gnt_id ? m1.araddr : m0.araddr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            grant_r   <= 1'b0;
            addr_r    <= '0;
            len_r     <= '0;
            size_r    <= '0;
            burst_r   <= '0;
            arvalid_r <= 1'b0;
            beat_cnt  <= '0;
            arb_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: if (idle_grant) begin
                    grant_r   <= gnt_id;
                    addr_r    <= sel_addr[ADDR_WIDTH-1:0];
                    len_r     <= gnt_id ? m1.arlen   : m0.arlen;
                    size_r    <= gnt_id ? m1.arsize  : m0.arsize;
                    burst_r   <= gnt_id ? m1.arburst : m0.arburst;
                    arvalid_r <= 1'b1;
                    state_r   <= ST_ADDR;
                end
                ST_ADDR: if (s_axi_arready) begin
                    arvalid_r <= 1'b0;
                    beat_cnt  <= '0;
                    state_r   <= ST_DATA;
                end
                ST_DATA: if (beat_hs) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    if (last_beat) state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase

            // Sticky: a wrong ID or misplaced slave rlast is flagged but data still flows.
            if (beat_hs && ((s_axi_rid != s_axi_arid) || (s_axi_rlast != last_beat)))
                arb_err_r <= 1'b1;
        end
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        m0.arready   = idle_grant && (gnt_id == INST_MASTER);
        m1.arready   = idle_grant && (gnt_id == DATA_MASTER);
        m0.rvalid    = 1'b0;
        m0.rdata     = '0;
        m0.rlast     = 1'b0;
        m1.rvalid    = 1'b0;
        m1.rdata     = '0;
        m1.rlast     = 1'b0;
        s_axi_rready = 1'b0;
        if (state_r == ST_DATA) begin
            if (grant_r == DATA_MASTER) begin
                m1.rvalid    = s_axi_rvalid;
                m1.rdata     = s_axi_rdata;
                m1.rlast     = last_beat;
                s_axi_rready = m1.rready;
            end else begin
                m0.rvalid    = s_axi_rvalid;
                m0.rdata     = s_axi_rdata;
                m0.rlast     = last_beat;
                s_axi_rready = m0.rready;
            end
        end
    end

    assign s_axi_arid    = {ID_WIDTH{grant_r}};
    assign s_axi_araddr  = addr_r;
    assign s_axi_arlen   = len_r;
    assign s_axi_arsize  = size_r;
    assign s_axi_arburst = burst_r;
    assign s_axi_arvalid = arvalid_r;
    assign s_axi_arlock  = 1'b0;
    assign s_axi_arcache = 4'b0000;
    assign s_axi_arprot  = 3'b000;
    assign arb_err       = arb_err_r;

    // rresp is deliberately dropped; upper master address bits are truncated.
    logic unused_ok;
    assign unused_ok = ^{s_axi_rresp, sel_addr};

`ifdef CPU_AXI_RD_ARB_PERF_EN
    logic [31:0] m0_grants_r, m1_grants_r, m0_wait_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m0_grants_r <= '0;
            m1_grants_r <= '0;
            m0_wait_r   <= '0;
        end else begin
            if (m0.arready) m0_grants_r <= m0_grants_r + 32'd1;
            if (m1.arready) m1_grants_r <= m1_grants_r + 32'd1;
            if (m0.arvalid && !m0.arready) m0_wait_r <= m0_wait_r + 32'd1;
        end
    end

    assign perf_m0_grants = m0_grants_r;
    assign perf_m1_grants = m1_grants_r;
    assign perf_m0_wait   = m0_wait_r;
`endif

endmodule

// File: tb/tb_cpu_axi_rd_rr_arb.sv
// Directed self-checking bench for cpu_axi_rd_rr_arb with a hand-driven AXI slave.
module tb_cpu_axi_rd_rr_arb;
    import cpu_axi_rd_rr_arb_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cpu_axi_rd_rr_arb_if #(.DATA_WIDTH(DW)) m0_if ();
    cpu_axi_rd_rr_arb_if #(.DATA_WIDTH(DW)) m1_if ();

    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arlock;
    logic [3:0]    s_axi_arcache;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic          arb_err;
`ifdef CPU_AXI_RD_ARB_PERF_EN
    logic [31:0] perf_m0_grants, perf_m1_grants, perf_m0_wait;
`endif

    cpu_axi_rd_rr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m0            (m0_if),
        .m1            (m1_if),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlock  (s_axi_arlock),
        .s_axi_arcache (s_axi_arcache),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .arb_err       (arb_err)
`ifdef CPU_AXI_RD_ARB_PERF_EN
        ,
        .perf_m0_grants(perf_m0_grants),
        .perf_m1_grants(perf_m1_grants),
        .perf_m0_wait  (perf_m0_wait)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit which, input logic [31:0] addr, input logic [7:0] len);
        if (which) begin
            m1_if.araddr = addr; m1_if.arlen = len; m1_if.arsize = AXI_SIZE_4B;
            m1_if.arburst = AXI_BURST_INCR; m1_if.arvalid = 1'b1;
        end else begin
            m0_if.araddr = addr; m0_if.arlen = len; m0_if.arsize = AXI_SIZE_4B;
            m0_if.arburst = AXI_BURST_INCR; m0_if.arvalid = 1'b1;
        end
    endtask

    // Expects IDLE with `which` winning this cycle; completes the master handshake.
    task automatic grant_phase(input bit which);
        #1;
        check("gnt_m0_arready", m0_if.arready, which == 1'b0);
        check("gnt_m1_arready", m1_if.arready, which == 1'b1);
        check("gnt_cycle_arvalid", s_axi_arvalid, 1'b0);
        tick();
        if (which) m1_if.arvalid = 1'b0; else m0_if.arvalid = 1'b0;
    endtask

    // From cycle 1 after grant: AR phase with ar_wait stall cycles, then len+1 clean beats.
    task automatic addr_data(input bit which, input int len, input logic [AW-1:0] addr, input int ar_wait);
        logic [IW-1:0] id;
        id = which ? DATA_ID : INST_ID;
        check("ar_valid", s_axi_arvalid, 1'b1);
        check("ar_id", s_axi_arid, id);
        check("ar_addr", s_axi_araddr, addr);
        check("ar_len", s_axi_arlen, len);
        check("ar_size", s_axi_arsize, AXI_SIZE_4B);
        check("ar_burst", s_axi_arburst, AXI_BURST_INCR);
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            check("ar_hold_valid", s_axi_arvalid, 1'b1);
            check("ar_hold_addr", s_axi_araddr, addr);
            check("ar_hold_len", s_axi_arlen, len);
            check("ar_hold_state", dut.state_r, ST_ADDR);
            check("ar_hold_no_grant", which ? m0_if.arready : m1_if.arready, 1'b0);
        end
        s_axi_arready = 1'b1;
        tick();
        s_axi_arready = 1'b0;
        check("ar_done_valid", s_axi_arvalid, 1'b0);
        check("ar_done_state", dut.state_r, ST_DATA);
        for (int b = 0; b <= len; b++) begin
            s_axi_rvalid = 1'b1;
            s_axi_rid    = id;
            s_axi_rlast  = (b == len);
            s_axi_rdata  = 32'hD000_0000 + b;
            if (which) m1_if.rready = 1'b1; else m0_if.rready = 1'b1;
            #1;
            check("beat_rvalid", which ? m1_if.rvalid : m0_if.rvalid, 1'b1);
            check("beat_other_rvalid", which ? m0_if.rvalid : m1_if.rvalid, 1'b0);
            check("beat_rdata", which ? m1_if.rdata : m0_if.rdata, 32'hD000_0000 + b);
            check("beat_rlast", which ? m1_if.rlast : m0_if.rlast, b == len);
            check("beat_s_rready", s_axi_rready, 1'b1);
            check("beat_no_grant", which ? m0_if.arready : m1_if.arready, 1'b0);
            tick();
        end
        s_axi_rvalid = 1'b0; s_axi_rlast = 1'b0;
        m0_if.rready = 1'b0; m1_if.rready = 1'b0;
        #1;
        check("burst_end_state", dut.state_r, ST_IDLE);
    endtask

    task automatic serve(input bit which, input int len, input logic [AW-1:0] addr);
        grant_phase(which);
        addr_data(which, len, addr, 0);
    endtask

    initial begin
        m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0; m0_if.arburst = '0;
        m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
        m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0; m1_if.arburst = '0;
        m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
        s_axi_arready = 1'b0; s_axi_rid = '0; s_axi_rdata = '0; s_axi_rresp = '0;
        s_axi_rlast = 1'b0; s_axi_rvalid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_arvalid", s_axi_arvalid, 1'b0);
        check("rst_rready", s_axi_rready, 1'b0);
        check("rst_m0_arready", m0_if.arready, 1'b0);
        check("rst_m1_rvalid", m1_if.rvalid, 1'b0);
        check("rst_arb_err", arb_err, 1'b0);
        check("rst_araddr", s_axi_araddr, '0);
        check("rst_arid", s_axi_arid, '0);
        check("rst_state", dut.state_r, ST_IDLE);
        check("rst_const", {s_axi_arlock, s_axi_arcache, s_axi_arprot}, 8'h00);
        resetn = 1'b1;

        // Single m0 burst of four beats
        req(1'b0, 32'h0000_0100, 8'd3);
        serve(1'b0, 3, 30'h100);

        // Contention straight after reset: m1, m0, m1, m0
        resetn = 1'b0;
        #2 resetn = 1'b1;
        req(1'b0, 32'h0000_0200, 8'd0);
        req(1'b1, 32'h0000_0300, 8'd1);
        serve(1'b1, 1, 30'h300);
        serve(1'b0, 0, 30'h200);
        req(1'b1, 32'h0000_0304, 8'd0);
        req(1'b0, 32'h0000_0204, 8'd0);
        serve(1'b1, 0, 30'h304);
        serve(1'b0, 0, 30'h204);

        // AR stalled five cycles with m1 waiting; address truncated to 30 bits
        req(1'b0, 32'hC000_0400, 8'd2);
        grant_phase(1'b0);
        req(1'b1, 32'h0000_0500, 8'd0);
        addr_data(1'b0, 2, 30'h400, 5);
        serve(1'b1, 0, 30'h500);

        // m1 single beat stalled by rready
        req(1'b1, 32'h0000_0600, 8'd0);
        grant_phase(1'b1);
        s_axi_arready = 1'b1;
        tick();
        s_axi_arready = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rid = DATA_ID; s_axi_rlast = 1'b1;
        s_axi_rdata = 32'hBEEF_0001; m1_if.rready = 1'b0;
        #1;
        check("stall_m1_rvalid", m1_if.rvalid, 1'b1);
        check("stall_s_rready", s_axi_rready, 1'b0);
        check("stall_m0_rvalid", m0_if.rvalid, 1'b0);
        check("stall_m1_rlast", m1_if.rlast, 1'b1);
        tick();
        check("stall_state", dut.state_r, ST_DATA);
        m1_if.rready = 1'b1;
        #1;
        check("stall_release_rready", s_axi_rready, 1'b1);
        check("stall_release_rdata", m1_if.rdata, 32'hBEEF_0001);
        tick();
        s_axi_rvalid = 1'b0; s_axi_rlast = 1'b0; m1_if.rready = 1'b0;
        check("stall_done_state", dut.state_r, ST_IDLE);
        check("stall_no_err", arb_err, 1'b0);

        // Slave rlast on beat 2 of a len-3 m1 burst
        req(1'b1, 32'h0000_0700, 8'd3);
        grant_phase(1'b1);
        s_axi_arready = 1'b1;
        tick();
        s_axi_arready = 1'b0;
        for (int b = 0; b <= 3; b++) begin
            s_axi_rvalid = 1'b1; s_axi_rid = DATA_ID; s_axi_rlast = (b == 1) || (b == 3);
            s_axi_rdata = 32'hE000_0000 + b; m1_if.rready = 1'b1;
            #1;
            check("early_rvalid", m1_if.rvalid, 1'b1);
            check("early_rlast_regen", m1_if.rlast, b == 3);
            tick();
            check("early_err", arb_err, b >= 1);
        end
        s_axi_rvalid = 1'b0; s_axi_rlast = 1'b0; m1_if.rready = 1'b0;
        check("early_done_state", dut.state_r, ST_IDLE);
        tick();
        check("early_err_sticky", arb_err, 1'b1);

        // Reset mid-DATA of an m0 burst (last completed grant was m1)
        req(1'b0, 32'h0000_0800, 8'd3);
        grant_phase(1'b0);
        s_axi_arready = 1'b1;
        tick();
        s_axi_arready = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rid = INST_ID; s_axi_rdata = 32'h1234_5678; m0_if.rready = 1'b1;
        tick();
        req(1'b0, 32'h0000_0880, 8'd0);
        req(1'b1, 32'h0000_0900, 8'd0);
        #2 resetn = 1'b0;
        #1;
        check("midrst_m0_rvalid", m0_if.rvalid, 1'b0);
        check("midrst_m0_rlast", m0_if.rlast, 1'b0);
        check("midrst_s_rready", s_axi_rready, 1'b0);
        check("midrst_arvalid", s_axi_arvalid, 1'b0);
        check("midrst_arb_err", arb_err, 1'b0);
        check("midrst_state", dut.state_r, ST_IDLE);
        check("midrst_m0_arready", m0_if.arready, 1'b0);
        check("midrst_m1_arready", m1_if.arready, 1'b0);
        s_axi_rvalid = 1'b0; m0_if.rready = 1'b0;
        resetn = 1'b1;
        serve(1'b1, 0, 30'h900);
        serve(1'b0, 0, 30'h880);

        // Maximum burst length: 256 beats, rlast only on the last
        req(1'b0, 32'h0000_1000, 8'd255);
        serve(1'b0, 255, 30'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
